mux_scan_ctrl: RTL and testbench
================================

Name: mux_scan_ctrl

Overview:
- Sequencer that drives the select lines of the 4:1 data mux and samples its output.
- Steps round-robin through the enabled channels, holding each select for a programmable settle time, then captures the mux output.
- Emits one valid-strobed sample per channel and a frame marker per completed pass.
- Sits directly upstream of the mux (drives s1/s0) and consumes its y output.

Parameters:
- DWELL_W, 8, width of the dwell (settle-cycle) count input.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the clk rising edge.
- en  input  1  scan enable.
- chan_mask  input  4  per-channel enable; bit i enables channel i.
- dwell  input  DWELL_W  settle cycles per channel; 0 is treated as 1.
- y_in  input  1  mux output being sampled.
- s0  output  1  select bit 0 to the mux.
- s1  output  1  select bit 1 to the mux.
- busy  output  1  high while not in IDLE.
- sample_valid  output  1  one-cycle strobe: new sample available.
- sample_chan  output  2  channel index of the current sample.
- sample_data  output  1  captured y_in value.
- sample_vec  output  4  last captured value for each channel.
- frame_done  output  1  one-cycle strobe, coincident with the sample_valid that closes a pass.

Behaviour:
- Reset (rst_n=0 at an edge):
  - s1, s0, busy, sample_valid, sample_chan, sample_data, frame_done, sample_vec all go to 0.
  - State goes to IDLE.
  - Reset applies mid-operation with no completion of the current channel.
- Select: {s1,s0} always equals the registered current channel index cur.
- States:
  - IDLE to SETTLE:
    - Transition occurs when en=1 and chan_mask!=0.
    - cur is loaded with the lowest set bit of chan_mask.
    - cnt is loaded with D, where D = (dwell==0) ? 1 : dwell.
    - busy=1 from this edge.
  - SETTLE:
    - cnt decrements each cycle.
    - When cnt==1, the next state is SAMPLE.
    - en and chan_mask are ignored in this state.
  - SAMPLE (exactly one cycle). At the closing edge:
    - sample_data <= y_in and sample_chan <= cur.
    - sample_vec[cur] <= y_in.
    - sample_valid <= 1 for one cycle.
    - nxt = first set bit of the current chan_mask strictly after cur, wrapping 3 to 0.
    - frame_done <= 1 if nxt <= cur (wrap or single channel) or the mask is empty.
    - If en=1 and chan_mask!=0: cur <= nxt, cnt <= D, next state SETTLE.
    - Otherwise: next state IDLE, cur holds, busy <= 0.
- Timing: select is stable for D+1 cycles per channel (D settle plus 1 sample). sample_valid rises on the same edge that the select changes.
- Per-channel period is D+1 cycles with back-to-back channels and no idle gaps.
- Mask changes take effect only at SAMPLE, or at IDLE exit. Clearing the bit of the channel in flight does not abort it.
- A dwell change is picked up at the next cnt load.
- Strobe outputs (sample_valid, frame_done) are 0 on every cycle not stated above.
- sample_data, sample_chan and sample_vec hold their values between strobes.

Decomposition:
- Package mux_scan_pkg:
  - state enum {IDLE, SETTLE, SAMPLE}.
  - NUM_CH=4 and SEL_W=2.
  - Helper function to convert dwell to D.
- Sub-module rr_next_chan (combinational): inputs mask[3:0] and cur[1:0]; outputs nxt[1:0], wrap, none.
  - Also used for the lowest-set-bit pick (cur=3 gives first-from-0).
  - Unit-testable exhaustively (64 cases).

Test Plan:
- Reset, all ones: rst_n=0 for 2 cycles with en=1 and mask=4'hF -> all outputs 0 and busy=0; the first SETTLE starts on the edge after rst_n rises.
- Full scan: mask=4'hF, dwell=3, y_in = channel-index parity (c=0,1,2,3 gives 0,1,1,0).
  - Select sequence 0,1,2,3,0 with 4 cycles per channel.
  - sample_chan 0,1,2,3 carrying data 0,1,1,0.
  - frame_done only with chan 3.
  - sample_vec=4'b0110.
- Sparse mask with dwell 0: mask=4'b1010, dwell=0 -> select alternates 1,3 every 2 cycles; frame_done with every chan-3 sample.
- Single channel: mask=4'b0100, dwell=2 -> select stays 2; sample_valid and frame_done every 3 cycles.
- Mid-scan changes: en dropped during SETTLE of ch1 -> ch1 sample still issued, then IDLE with busy=0 and select held at 1. Separately, mask changed from F to 4'b0001 during ch2 -> ch2 completes, next channel 0, frame_done=1.
- Mid-operation reset: rst_n=0 during SAMPLE -> no sample_valid on the following cycle, all outputs 0, and sample_vec cleared.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// Shared constants and helpers for the mux scan sequencer.
//   NUM_CH / SEL_W : channel count and select width of the 4:1 mux
//   ST_*           : sequencer state encodings
//   eff_dwell()    : maps a raw dwell value to the settle count actually used
package mux_scan_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned ST_W   = 2;

    typedef logic [ST_W-1:0] state_t;

    localparam logic [ST_W-1:0] ST_IDLE   = 2'd0;
    localparam logic [ST_W-1:0] ST_SETTLE = 2'd1;
    localparam logic [ST_W-1:0] ST_SAMPLE = 2'd2;

    // A dwell of zero still needs one settle cycle.
    function automatic logic [31:0] eff_dwell(input logic [31:0] dwell);
        return (dwell == 32'd0) ? 32'd1 : dwell;
    endfunction

endpackage

// File: rtl/rr_next_chan.sv
// Round-robin channel picker (purely combinational).
//   mask : per-channel enable
//   cur  : reference channel; search starts strictly after it, wrapping 3 -> 0
//   nxt  : first enabled channel after cur (cur itself if it is the only one)
//   wrap : nxt <= cur, i.e. the search passed channel 3 or stayed put
//   none : mask is empty
// With cur = 3 the result is the lowest set bit of mask.
module rr_next_chan
    import mux_scan_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [SEL_W-1:0]  cur,
    output logic [SEL_W-1:0]  nxt,
    output logic              wrap,
    output logic              none
);

    logic             found;
    logic [SEL_W-1:0] idx;

    // Scan cur+1 .. cur+4 modulo 4; the final step revisits cur itself.
    always_comb begin
        nxt   = cur;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            idx = SEL_W'(32'(cur) + k);
            if (!found && mask[idx]) begin
                nxt   = idx;
                found = 1'b1;
            end
        end
        none = (mask == '0);
        wrap = (nxt <= cur);
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a 4:1 data mux: walks the enabled channels round-robin,
// holds each select for a programmable settle time, then samples the mux output.
//   clk, rst_n        : clock, synchronous active-low reset
//   en, chan_mask     : scan enable and per-channel enable
//   dwell             : settle cycles per channel (0 behaves as 1)
//   y_in              : mux output being sampled
//   s1, s0            : mux select (always the current channel)
//   busy              : sequencer not idle
//   sample_valid      : one-cycle strobe with sample_chan / sample_data
//   sample_vec        : last captured value per channel
//   frame_done        : one-cycle strobe on the sample that closes a pass
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [NUM_CH-1:0]  chan_mask,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               y_in,
    output logic               s0,
    output logic               s1,
    output logic               busy,
    output logic               sample_valid,
    output logic [SEL_W-1:0]   sample_chan,
    output logic               sample_data,
    output logic [NUM_CH-1:0]  sample_vec,
    output logic               frame_done
);

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   cur_q, cur_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               valid_q, valid_d;
    logic [SEL_W-1:0]   chan_q, chan_d;
    logic               data_q, data_d;
    logic [NUM_CH-1:0]  vec_q, vec_d;
    logic               frame_q, frame_d;

    logic [SEL_W-1:0]   rr_cur;
    logic [SEL_W-1:0]   rr_nxt;
    logic               rr_wrap;
    logic               rr_none;
    logic               scan_go;
    logic [DWELL_W-1:0] d_load;

    // In IDLE, searching after channel 3 yields the lowest enabled channel.
    assign rr_cur  = (state_q == ST_IDLE) ? SEL_W'(NUM_CH - 1) : cur_q;
    assign scan_go = en && (chan_mask != '0);
    assign d_load  = DWELL_W'(eff_dwell(32'(dwell)));

    rr_next_chan u_rr (
        .mask (chan_mask),
        .cur  (rr_cur),
        .nxt  (rr_nxt),
        .wrap (rr_wrap),
        .none (rr_none)
    );

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cur_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            chan_q  <= '0;
            data_q  <= 1'b0;
            vec_q   <= '0;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            chan_q  <= chan_d;
            data_q  <= data_d;
            vec_q   <= vec_d;
            frame_q <= frame_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        frame_d = 1'b0;
        chan_d  = chan_q;
        data_d  = data_q;
        vec_d   = vec_q;

        case (state_q)
            ST_IDLE: begin
                if (scan_go) begin
                    state_d = ST_SETTLE;
                    cur_d   = rr_nxt;
                    cnt_d   = d_load;
                    busy_d  = 1'b1;
                end
            end

            // en and chan_mask are deliberately not looked at while settling.
            ST_SETTLE: begin
                cnt_d = cnt_q - DWELL_W'(1);
                if (cnt_q == DWELL_W'(1)) begin
                    state_d = ST_SAMPLE;
                end
            end

            ST_SAMPLE: begin
                valid_d       = 1'b1;
                chan_d        = cur_q;
                data_d        = y_in;
                vec_d[cur_q]  = y_in;
                frame_d       = rr_wrap || rr_none;
                if (scan_go) begin
                    state_d = ST_SETTLE;
                    cur_d   = rr_nxt;
                    cnt_d   = d_load;
                end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign s0           = cur_q[0];
    assign s1           = cur_q[1];
    assign busy         = busy_q;
    assign sample_valid = valid_q;
    assign sample_chan  = chan_q;
    assign sample_data  = data_q;
    assign sample_vec   = vec_q;
    assign frame_done   = frame_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl: directed scenarios plus random
// stimulus, all compared against a cycle-scheduled behavioural model.
module tb_mux_scan_ctrl;

    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [3:0]    chan_mask;
    logic [DW-1:0] dwell;
    logic          y_in;
    logic [3:0]    mux_data;
    logic          s0, s1, busy, sample_valid, sample_data, frame_done;
    logic [1:0]    sample_chan;
    logic [3:0]    sample_vec;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Behavioural model: absolute-time schedule of sample edges.
    logic       m_active = 1'b0;
    logic [1:0] m_cur    = 2'd0;
    int         m_end    = 0;
    logic       m_valid  = 1'b0;
    logic [1:0] m_chan   = 2'd0;
    logic       m_data   = 1'b0;
    logic [3:0] m_vec    = 4'd0;
    logic       m_frame  = 1'b0;

    always #5 clk = ~clk;

    // The mux being scanned.
    assign y_in = mux_data[{s1, s0}];

    mux_scan_ctrl #(.DWELL_W(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .chan_mask    (chan_mask),
        .dwell        (dwell),
        .y_in         (y_in),
        .s0           (s0),
        .s1           (s1),
        .busy         (busy),
        .sample_valid (sample_valid),
        .sample_chan  (sample_chan),
        .sample_data  (sample_data),
        .sample_vec   (sample_vec),
        .frame_done   (frame_done)
    );

    wire [11:0] obs  = {busy, s1, s0, sample_valid, sample_chan, sample_data, sample_vec, frame_done};
    wire [11:0] expv = {m_active, m_cur, m_valid, m_chan, m_data, m_vec, m_frame};

    // First enabled channel strictly after c, wrapping; c itself if it is the only one.
    function automatic logic [1:0] next_after(input logic [3:0] m, input logic [1:0] c);
        logic [1:0] r;
        r = c;
        for (int k = 4; k >= 1; k--) begin
            if (m[(int'(c) + k) % 4]) r = 2'((int'(c) + k) % 4);
        end
        return r;
    endfunction

    initial begin
        int         d;
        logic [1:0] n;
        forever begin
            @(posedge clk);
            cyc++;
            m_valid = 1'b0;
            m_frame = 1'b0;
            d = (dwell == '0) ? 1 : int'(dwell);
            if (!rst_n) begin
                m_active = 1'b0;
                m_cur    = 2'd0;
                m_chan   = 2'd0;
                m_data   = 1'b0;
                m_vec    = 4'd0;
            end else if (!m_active) begin
                if (en && chan_mask != 4'd0) begin
                    m_active = 1'b1;
                    m_cur    = next_after(chan_mask, 2'd3);
                    m_end    = cyc + d + 1;
                end
            end else if (cyc == m_end) begin
                m_valid        = 1'b1;
                m_chan         = m_cur;
                m_data         = y_in;
                m_vec[m_cur]   = y_in;
                n              = next_after(chan_mask, m_cur);
                m_frame        = (chan_mask == 4'd0) || (n <= m_cur);
                if (en && chan_mask != 4'd0) begin
                    m_cur = n;
                    m_end = cyc + d + 1;
                end else begin
                    m_active = 1'b0;
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        en    = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; en = 1'b1; chan_mask = 4'hF; dwell = 8'd3; mux_data = 4'b0110;
        repeat (2) begin
            @(negedge clk);
            total++;
            if (obs !== 12'd0) begin
                bad++; $display("FAIL reset_outputs: got %h want 000", obs);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b1 || {s1, s0} !== 2'd0 || sample_valid !== 1'b0) begin
            bad++; $display("FAIL reset_release_start: busy=%b sel=%0d valid=%b want 1 0 0", busy, {s1, s0}, sample_valid);
        end
        total++;
        if (obs !== expv) begin
            bad++; $display("FAIL reset_model: got %h want %h", obs, expv);
        end
    endtask

    task automatic test_full_scan();
        logic [1:0] q_sel[$];
        logic [1:0] q_chan[$];
        logic       q_data[$];
        logic       q_frame[$];
        int         q_cyc[$];
        logic [3:0] want_data;
        want_data = 4'b0110;
        do_reset();
        en = 1'b1; chan_mask = 4'hF; dwell = 8'd3; mux_data = 4'b0110;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            total++;
            if (obs !== expv) begin
                bad++; $display("FAIL full_scan_model cyc=%0d: got %h want %h", cyc, obs, expv);
            end
            if (q_sel.size() == 0 || q_sel[$] != {s1, s0}) q_sel.push_back({s1, s0});
            if (sample_valid === 1'b1) begin
                q_chan.push_back(sample_chan);
                q_data.push_back(sample_data);
                q_frame.push_back(frame_done);
                q_cyc.push_back(cyc);
            end
        end
        total++;
        if (q_sel.size() != 5 || q_chan.size() != 4) begin
            bad++; $display("FAIL full_scan_counts: sel_changes=%0d samples=%0d want 5 4", q_sel.size(), q_chan.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                total++;
                if (q_sel[i] !== 2'(i % 4)) begin
                    bad++; $display("FAIL full_scan_sel[%0d]: got %0d want %0d", i, q_sel[i], i % 4);
                end
            end
            for (int i = 0; i < 4; i++) begin
                total++;
                if (q_chan[i] !== 2'(i) || q_data[i] !== want_data[i] || q_frame[i] !== (i == 3)) begin
                    bad++; $display("FAIL full_scan_sample[%0d]: chan=%0d data=%b frame=%b want %0d %b %b",
                                    i, q_chan[i], q_data[i], q_frame[i], i, want_data[i], i == 3);
                end
                if (i > 0) begin
                    total++;
                    if (q_cyc[i] - q_cyc[i-1] != 4) begin
                        bad++; $display("FAIL full_scan_period[%0d]: got %0d want 4", i, q_cyc[i] - q_cyc[i-1]);
                    end
                end
            end
        end
        total++;
        if (sample_vec !== 4'b0110) begin
            bad++; $display("FAIL full_scan_vec: got %b want 0110", sample_vec);
        end
    endtask

    task automatic test_sparse();
        int nvalid = 0;
        int nframe = 0;
        int nch3   = 0;
        do_reset();
        en = 1'b1; chan_mask = 4'b1010; dwell = 8'd0; mux_data = 4'($urandom);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            total++;
            if (obs !== expv) begin
                bad++; $display("FAIL sparse_model cyc=%0d: got %h want %h", cyc, obs, expv);
            end
            total++;
            if ({s1, s0} !== 2'd1 && {s1, s0} !== 2'd3) begin
                bad++; $display("FAIL sparse_sel: got %0d want 1 or 3", {s1, s0});
            end
            if (sample_valid === 1'b1) nvalid++;
            if (frame_done === 1'b1) nframe++;
            if (sample_valid === 1'b1 && sample_chan === 2'd3) nch3++;
            mux_data = 4'($urandom);
        end
        total++;
        if (nvalid != 7 || nframe != 3 || nch3 != 3) begin
            bad++; $display("FAIL sparse_counts: valid=%0d frame=%0d ch3=%0d want 7 3 3", nvalid, nframe, nch3);
        end
    endtask

    task automatic test_single();
        int nvalid = 0;
        int nframe = 0;
        do_reset();
        en = 1'b1; chan_mask = 4'b0100; dwell = 8'd2; mux_data = 4'($urandom);
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            total++;
            if (obs !== expv) begin
                bad++; $display("FAIL single_model cyc=%0d: got %h want %h", cyc, obs, expv);
            end
            total++;
            if ({s1, s0} !== 2'd2) begin
                bad++; $display("FAIL single_sel: got %0d want 2", {s1, s0});
            end
            if (sample_valid === 1'b1) nvalid++;
            if (frame_done === 1'b1 && sample_valid === 1'b1) nframe++;
            mux_data = 4'($urandom);
        end
        total++;
        if (nvalid != 4 || nframe != 4) begin
            bad++; $display("FAIL single_counts: valid=%0d frame=%0d want 4 4", nvalid, nframe);
        end
    endtask

    task automatic test_en_drop();
        logic dropped = 1'b0;
        logic got     = 1'b0;
        do_reset();
        en = 1'b1; chan_mask = 4'hF; dwell = 8'd4; mux_data = 4'b1010;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            total++;
            if (obs !== expv) begin
                bad++; $display("FAIL en_drop_model cyc=%0d: got %h want %h", cyc, obs, expv);
            end
            if (dropped && sample_valid === 1'b1) begin
                got = 1'b1;
                total++;
                if (sample_chan !== 2'd1 || sample_data !== 1'b1 || busy !== 1'b0 || {s1, s0} !== 2'd1) begin
                    bad++; $display("FAIL en_drop_sample: chan=%0d data=%b busy=%b sel=%0d want 1 1 0 1",
                                    sample_chan, sample_data, busy, {s1, s0});
                end
            end
            if (!dropped && {s1, s0} === 2'd1) begin
                dropped = 1'b1;
                en      = 1'b0;
            end
        end
        total++;
        if (!got) begin
            bad++; $display("FAIL en_drop_timeout: got no ch1 sample want one");
        end
        repeat (3) begin
            @(negedge clk);
            total++;
            if (busy !== 1'b0 || {s1, s0} !== 2'd1 || sample_valid !== 1'b0) begin
                bad++; $display("FAIL en_drop_idle: busy=%b sel=%0d valid=%b want 0 1 0", busy, {s1, s0}, sample_valid);
            end
        end
    endtask

    task automatic test_mask_change();
        logic changed = 1'b0;
        logic got     = 1'b0;
        do_reset();
        en = 1'b1; chan_mask = 4'hF; dwell = 8'd3; mux_data = 4'b0100;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            total++;
            if (obs !== expv) begin
                bad++; $display("FAIL mask_chg_model cyc=%0d: got %h want %h", cyc, obs, expv);
            end
            if (changed && sample_valid === 1'b1) begin
                got = 1'b1;
                total++;
                if (sample_chan !== 2'd2 || sample_data !== 1'b1 || frame_done !== 1'b1 || {s1, s0} !== 2'd0) begin
                    bad++; $display("FAIL mask_chg_sample: chan=%0d data=%b frame=%b sel=%0d want 2 1 1 0",
                                    sample_chan, sample_data, frame_done, {s1, s0});
                end
            end
            if (!changed && {s1, s0} === 2'd2) begin
                changed   = 1'b1;
                chan_mask = 4'b0001;
            end
        end
        total++;
        if (!got) begin
            bad++; $display("FAIL mask_chg_timeout: got no ch2 sample want one");
        end
    endtask

    task automatic test_mid_reset();
        logic hit = 1'b0;
        do_reset();
        en = 1'b1; chan_mask = 4'hF; dwell = 8'd2; mux_data = 4'hF;
        for (int i = 0; i < 60 && !hit; i++) begin
            @(negedge clk);
            total++;
            if (obs !== expv) begin
                bad++; $display("FAIL mid_rst_model cyc=%0d: got %h want %h", cyc, obs, expv);
            end
            // Next edge closes a sample once every channel has been captured.
            if (sample_vec === 4'hF && m_active && m_end == cyc + 1) begin
                hit   = 1'b1;
                rst_n = 1'b0;
            end
        end
        total++;
        if (!hit) begin
            bad++; $display("FAIL mid_rst_timeout: never reached a sample cycle");
        end
        @(negedge clk);
        total++;
        if (sample_valid !== 1'b0 || obs !== 12'd0) begin
            bad++; $display("FAIL mid_rst_outputs: valid=%b obs=%h want 0 000", sample_valid, obs);
        end
        rst_n = 1'b1;
        en    = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        en = 1'b1; chan_mask = 4'($urandom); dwell = DW'($urandom_range(0, 5)); mux_data = 4'($urandom);
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            total++;
            if (obs !== expv) begin
                bad++; $display("FAIL random_model cyc=%0d: got %h want %h", cyc, obs, expv);
            end
            rst_n    = ($urandom_range(0, 199) != 0);
            en       = ($urandom_range(0, 9) != 0);
            mux_data = 4'($urandom);
            if ($urandom_range(0, 9) == 0) chan_mask = 4'($urandom);
            if ($urandom_range(0, 9) == 0) dwell = DW'($urandom_range(0, 5));
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; chan_mask = 4'd0; dwell = '0; mux_data = 4'd0;
        test_reset();
        test_full_scan();
        test_sparse();
        test_single();
        test_en_drop();
        test_mask_change();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
